subtractor_serial: RTL

//  Multi-cycle bit-serial subtractor, the inverse operation of our ripple-carry adder:

---
 rtl/subtractor_serial.sv | 120 ++++++++++++
 1 files changed

// File: rtl/subtractor_serial.sv
// Bit-serial subtractor D = A - B - Bin. One bit is processed per clock, LSB first,
// through a single full-subtractor stage with a registered borrow.
module subtractor_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             amsb_q, amsb_d, bmsb_q, bmsb_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             bout_q, bout_d, v_q, v_d;

  logic             a_i, b_i, d_i, br_nx;

  // Full-subtractor slice on the current LSB of the working registers.
  assign a_i   = a_q[0];
  assign b_i   = b_q[0];
  assign d_i   = a_i ^ b_i ^ br_q;
  assign br_nx = (~a_i & b_i) | (~(a_i ^ b_i) & br_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    dout_d  = dout_q;
    bout_d  = bout_q;
    v_d     = v_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          br_d    = Bin;
          amsb_d  = A[WIDTH-1];
          bmsb_d  = B[WIDTH-1];
          res_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_nx;
        res_d = {d_i, res_q[WIDTH-1:1]};
        if (cnt_q == LAST) begin
          // d_i is the final MSB; results are published only here.
          dout_d  = {d_i, res_q[WIDTH-1:1]};
          bout_d  = br_nx;
          v_d     = (amsb_q ^ bmsb_q) & (amsb_q ^ d_i);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      dout_q  <= '0;
      bout_q  <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      dout_q  <= dout_d;
      bout_q  <= bout_d;
      v_q     <= v_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign D    = dout_q;
  assign Bout = bout_q;
  assign V    = v_q;

endmodule
